arb5_rr: RTL and testbench

Round-robin arbiter and sequencer that shares one 5-input datapath resource among five requesters. It produces the registered one-hot select that drives the shared 5-way one-hot multiplexer (bit i selects input i), so exactly zero or one bit is ever set. It holds each grant until the resource acknowledges completion, the owner withdraws, or a timeout expires. It sits between the requesting units (e.g. PC/ALU/memory-side producers) and the shared operand/bus mux.

---
 rtl/arb5_rr.sv | 152 +++++++++++++++
 tb/tb_arb5_rr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/arb5_rr.sv
`default_nettype none
// ============================================================================
//  Module   : arb5_rr
//  Purpose  : Round-robin arbiter/sequencer sharing one 5-input datapath
//             resource. Produces a registered one-hot mux select and holds
//             each grant until ack, owner withdrawal, or timeout.
//  Ports    : clk         - rising-edge clock
//             rst         - synchronous active-high reset
//             req[4:0]    - level-sensitive requests, bit i = requester i
//             ack         - current transaction complete (ignored when idle)
//             grant[4:0]  - registered one-hot select, 0 when idle
//             busy        - registered, high while a grant is held
//             owner[2:0]  - registered index of current/most recent owner
//             timeout_err - registered one-cycle pulse after forced release
//  Revision : 1.0 - initial release
// ============================================================================
module arb5_rr #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic       ack,
    output logic [4:0] grant,
    output logic       busy,
    output logic [2:0] owner,
    output logic       timeout_err
);

    // Last count value before a forced release; unused when TIMEOUT is 0.
    localparam logic [7:0] c_to_last = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam bit         c_to_en   = (TIMEOUT != 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_ptr, w_ptr_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [4:0] r_grant, w_grant_nxt;
    logic [2:0] r_owner, w_owner_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_terr, w_terr_nxt;

    logic       w_to_hit;
    logic       w_release;
    logic [2:0] w_base;
    logic [3:0] w_pick;     // {found, index}

    // Index following i in the cyclic order 0..4.
    function automatic logic [2:0] f_next(input logic [2:0] i);
        return (i == 3'd4) ? 3'd0 : i + 3'd1;
    endfunction

    // First requester at or after base, cyclically. Scanning offsets from
    // farthest to nearest lets the nearest hit overwrite the result.
    function automatic logic [3:0] f_pick(input logic [4:0] rq, input logic [2:0] base);
        logic [3:0] res;
        logic [3:0] sum;
        res = 4'b0000;
        for (int k = 4; k >= 0; k--) begin
            sum = {1'b0, base} + 4'(k);
            if (sum >= 4'd5) begin
                sum = sum - 4'd5;
            end
            if (rq[sum[2:0]]) begin
                res = {1'b1, sum[2:0]};
            end
        end
        return res;
    endfunction

    assign w_to_hit  = c_to_en && (r_cnt == c_to_last);
    assign w_release = ack | ~req[r_owner] | w_to_hit;

    // On hand-over the search starts just past the releasing owner, so the
    // old owner is still eligible but at lowest priority.
    assign w_base = (r_state == ST_OWN) ? f_next(r_owner) : r_ptr;
    assign w_pick = f_pick(req, w_base);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_terr_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick[3]) begin
                    w_state_nxt = ST_OWN;
                    w_grant_nxt = 5'd1 << w_pick[2:0];
                    w_owner_nxt = w_pick[2:0];
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_OWN: begin
                if (w_release) begin
                    w_ptr_nxt  = f_next(r_owner);
                    // ack wins over a simultaneous timeout.
                    w_terr_nxt = w_to_hit & ~ack;
                    if (w_pick[3]) begin
                        w_grant_nxt = 5'd1 << w_pick[2:0];
                        w_owner_nxt = w_pick[2:0];
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 5'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 5'd0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_OWN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_cnt   <= 8'd0;
            r_grant <= 5'd0;
            r_owner <= 3'd0;
            r_busy  <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= w_busy_nxt;
            r_terr  <= w_terr_nxt;
        end
    end

    assign grant       = r_grant;
    assign busy        = r_busy;
    assign owner       = r_owner;
    assign timeout_err = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_arb5_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arb5_rr
//  Purpose  : Self-checking bench for arb5_rr. A behavioural model tracks the
//             expected owner/pointer/count; a compare process checks every
//             cycle and directed scenarios pin literal expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arb5_rr;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic       ack;
    logic [4:0] grant;
    logic       busy;
    logic [2:0] owner;
    logic       timeout_err;

    int vectors    = 0;
    int miscompares = 0;
    bit cmp_en     = 1'b0;

    // Model state
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_terr  = 1'b0;

    arb5_rr #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .grant       (grant),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic int winner(input logic [4:0] rq, input int start);
        for (int k = 0; k < 5; k++) begin
            if (rq[(start + k) % 5]) return (start + k) % 5;
        end
        return -1;
    endfunction

    // Behavioural model, advanced on each rising edge from the inputs the
    // stimulus drove at the preceding falling edge.
    always @(posedge clk) begin
        int w;
        bit rel, forced;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_terr = 0;
        end else if (!m_busy) begin
            m_terr = 0;
            w = winner(req, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_cnt = 0;
            end
        end else begin
            forced = (TO != 0) && (m_cnt == TO - 1) && !ack;
            rel    = ack || !req[m_owner] || forced;
            m_terr = forced;
            if (rel) begin
                m_ptr = (m_owner + 1) % 5;
                w = winner(req, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_cnt = 0;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_cnt = (m_cnt + 1) % 256;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic [4:0] eg;
        if (cmp_en) begin
            eg = m_busy ? (5'd1 << m_owner) : 5'd0;
            vectors++;
            if (grant !== eg || busy !== m_busy || owner !== 3'(m_owner) ||
                timeout_err !== m_terr) begin
                miscompares++;
                $display("FAIL model t=%0t: got grant=%b busy=%b owner=%0d terr=%b, want grant=%b busy=%b owner=%0d terr=%b",
                         $time, grant, busy, owner, timeout_err, eg, m_busy, m_owner, m_terr);
            end
        end
    end

    task automatic step(input logic [4:0] r, input logic a, input logic rs);
        req = r; ack = a; rst = rs;
        @(negedge clk);
    endtask

    task automatic expect_out(input string nm, input logic [4:0] g, input logic b,
                              input logic [2:0] o, input logic t);
        vectors++;
        if (grant !== g || busy !== b || owner !== o || timeout_err !== t) begin
            miscompares++;
            $display("FAIL %s: got grant=%b busy=%b owner=%0d terr=%b, want grant=%b busy=%b owner=%0d terr=%b",
                     nm, grant, busy, owner, timeout_err, g, b, o, t);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req = 5'b0; ack = 1'b0; rst = 1'b1;
        // Reset with everything requesting and ack high.
        step(5'b11111, 1'b1, 1'b1);
        cmp_en = 1'b1;
        expect_out("reset1", 5'b00000, 0, 3'd0, 0);
        step(5'b11111, 1'b1, 1'b1);
        expect_out("reset2", 5'b00000, 0, 3'd0, 0);
        step(5'b11111, 1'b0, 1'b0);
        expect_out("first_grant", 5'b00001, 1, 3'd0, 0);

        // Rotation with ack every cycle.
        step(5'b11111, 1'b1, 1'b0); expect_out("rot1", 5'b00010, 1, 3'd1, 0);
        step(5'b11111, 1'b1, 1'b0); expect_out("rot2", 5'b00100, 1, 3'd2, 0);
        step(5'b11111, 1'b1, 1'b0); expect_out("rot3", 5'b01000, 1, 3'd3, 0);
        step(5'b11111, 1'b1, 1'b0); expect_out("rot4", 5'b10000, 1, 3'd4, 0);
        step(5'b11111, 1'b1, 1'b0); expect_out("rot0", 5'b00001, 1, 3'd0, 0);
        step(5'b00000, 1'b1, 1'b0); expect_out("rot_idle", 5'b00000, 0, 3'd0, 0);

        // Single requester held three cycles, then a new request.
        step(5'b00100, 1'b0, 1'b0); expect_out("single_g", 5'b00100, 1, 3'd2, 0);
        step(5'b00100, 1'b0, 1'b0); expect_out("single_h1", 5'b00100, 1, 3'd2, 0);
        step(5'b00100, 1'b0, 1'b0); expect_out("single_h2", 5'b00100, 1, 3'd2, 0);
        step(5'b00000, 1'b1, 1'b0); expect_out("single_rel", 5'b00000, 0, 3'd2, 0);
        step(5'b00001, 1'b0, 1'b0); expect_out("single_next", 5'b00001, 1, 3'd0, 0);
        step(5'b00000, 1'b1, 1'b0);

        // Back-to-back hand-over with wrap from owner 4.
        step(5'b10000, 1'b0, 1'b0); expect_out("wrap_own4", 5'b10000, 1, 3'd4, 0);
        step(5'b10011, 1'b1, 1'b0); expect_out("wrap_0", 5'b00001, 1, 3'd0, 0);
        step(5'b10011, 1'b1, 1'b0); expect_out("wrap_1", 5'b00010, 1, 3'd1, 0);
        step(5'b10011, 1'b1, 1'b0); expect_out("wrap_4", 5'b10000, 1, 3'd4, 0);
        step(5'b00000, 1'b1, 1'b0); expect_out("wrap_idle", 5'b00000, 0, 3'd4, 0);

        // Timeout: held TO cycles, forced release re-grants the same requester.
        step(5'b00010, 1'b0, 1'b0); expect_out("to_grant", 5'b00010, 1, 3'd1, 0);
        for (int i = 0; i < TO - 1; i++) begin
            step(5'b00010, 1'b0, 1'b0); expect_out("to_hold", 5'b00010, 1, 3'd1, 0);
        end
        step(5'b00010, 1'b0, 1'b0); expect_out("to_pulse", 5'b00010, 1, 3'd1, 1);
        step(5'b00010, 1'b0, 1'b0); expect_out("to_pulse_end", 5'b00010, 1, 3'd1, 0);
        step(5'b00000, 1'b1, 1'b0);

        // ack on the timeout cycle suppresses the pulse.
        step(5'b00010, 1'b0, 1'b0);
        for (int i = 0; i < TO - 1; i++) step(5'b00010, 1'b0, 1'b0);
        step(5'b00010, 1'b1, 1'b0); expect_out("to_ack_wins", 5'b00010, 1, 3'd1, 0);
        step(5'b00000, 1'b1, 1'b0);

        // Withdrawal by owner 3 moves the pointer to 4; then reset mid-grant.
        step(5'b01000, 1'b0, 1'b0); expect_out("wd_own3", 5'b01000, 1, 3'd3, 0);
        step(5'b10001, 1'b0, 1'b0); expect_out("wd_ptr4", 5'b10000, 1, 3'd4, 0);
        step(5'b10001, 1'b0, 1'b1); expect_out("rst_busy", 5'b00000, 0, 3'd0, 0);
        step(5'b10001, 1'b0, 1'b0); expect_out("rst_ptr0", 5'b00001, 1, 3'd0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [4:0] r;
            r = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) r = r & 5'($urandom_range(0, 31));
            step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
        end

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
